// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with a 2-bit saturating counter per
// entry. Prediction for the fetch PC is combinational from registered state;
// branches and jumps resolved in EX update the table on the next rising edge
// and are checked here against the prediction they carried down the pipe.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    // fetch-side lookup
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    // EX-side resolution
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jump,
    input  logic [31:0] ex_pc,
    input  logic        ex_bcond,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_pc,
    output logic        mispredict,
    output logic [31:0] correct_pc,
    // statistics
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Two-bit direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Table state, one slot per index.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];

    // Predict from the pre-update table; a same-cycle update is not bypassed.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        if_hit     = 1'b0;
        pred_taken = 1'b0;
        pred_pc    = if_pc + 32'd4;
        if (valid_q[if_idx] && (tag_q[if_idx] == if_tag)) begin
            if_hit = 1'b1;
        end
        if (if_hit && ctr_q[if_idx][1]) begin
            pred_taken = 1'b1;
            pred_pc    = target_q[if_idx];
        end
    end

    // ------------------------------------------------------------------
    // EX resolution
    // ------------------------------------------------------------------
    logic             ex_is_ctrl;
    logic             update_en;
    logic             act_taken;
    logic [31:0]      ex_seq_pc;
    logic [31:0]      act_pc;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    ctr_e             ctr_next;

    assign ex_is_ctrl = ex_is_branch || ex_is_jump;
    assign update_en  = ex_valid && ex_is_ctrl;
    assign ex_seq_pc  = ex_pc + 32'd4;
    // A jump is always taken; with both flags set it is treated as a jump.
    assign act_taken  = ex_is_jump || (ex_is_branch && ex_bcond);
    assign act_pc     = act_taken ? ex_target : ex_seq_pc;
    assign ex_idx     = ex_pc[IDX_W+1:2];
    assign ex_tag     = ex_pc[31:IDX_W+2];
    assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Flag a mispredict when either the direction or the next PC disagrees.
    always_comb begin
        mispredict = 1'b0;
        correct_pc = ex_seq_pc;
        if (update_en && ((act_taken != ex_pred_taken) || (act_pc != ex_pred_pc))) begin
            mispredict = 1'b1;
            correct_pc = act_pc;
        end
    end

    // Next counter value for a hitting entry: jumps saturate to ST, branches
    // step one position toward the resolved direction and saturate.
    always_comb begin
        ctr_next = ctr_q[ex_idx];
        if (ex_is_jump) begin
            ctr_next = ST;
        end else if (ex_bcond) begin
            case (ctr_q[ex_idx])
                SNT:     ctr_next = WNT;
                WNT:     ctr_next = WT;
                default: ctr_next = ST;
            endcase
        end else begin
            case (ctr_q[ex_idx])
                ST:      ctr_next = WT;
                WT:      ctr_next = WNT;
                default: ctr_next = SNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State update: table and statistics, reset has priority
    // ------------------------------------------------------------------
    // Update the table on resolved control flow; reset clears everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the table is a register array, not a RAM macro, so it is
            // cleared here; the valid bits and counters must start known.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= WNT;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (update_en) begin
            branch_count <= branch_count + 32'd1;
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
            if (ex_hit) begin
                ctr_q[ex_idx] <= ctr_next;
                if (act_taken) begin
                    target_q[ex_idx] <= ex_target;
                end
            end else if (act_taken) begin
                // Allocate over whatever occupied this index.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= ex_is_jump ? ST : WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// random traffic, all compared against a table model kept in plain arithmetic.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_bcond;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_pc;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int unsigned n_asserts = 0;
    int unsigned n_fails   = 0;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_is_jump       (ex_is_jump),
        .ex_pc            (ex_pc),
        .ex_bcond         (ex_bcond),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_pc       (ex_pred_pc),
        .mispredict       (mispredict),
        .correct_pc       (correct_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: counters as integers 0..3, taken when >= 2
    // ------------------------------------------------------------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_bc;
    logic [31:0] m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic void m_predict(input logic [31:0] pc, output logic t, output logic [31:0] npc);
        int i;
        i   = idx_of(pc);
        t   = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        npc = t ? m_target[i] : pc + 32'd4;
    endfunction

    function automatic void m_resolve(output logic taken, output logic [31:0] apc,
                                      output logic mis, output logic [31:0] cpc);
        taken = ex_is_jump || (ex_is_branch && ex_bcond);
        apc   = taken ? ex_target : ex_pc + 32'd4;
        mis   = ex_valid && (ex_is_branch || ex_is_jump) &&
                ((taken != ex_pred_taken) || (apc != ex_pred_pc));
        cpc   = mis ? apc : ex_pc + 32'd4;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
        m_bc = '0;
        m_mc = '0;
    endfunction

    // Apply what the rising edge does, from the inputs held across it.
    function automatic void m_clock();
        logic        taken;
        logic [31:0] apc;
        logic        mis;
        logic [31:0] cpc;
        int          i;
        if (reset) begin
            m_reset();
        end else if (ex_valid && (ex_is_branch || ex_is_jump)) begin
            m_resolve(taken, apc, mis, cpc);
            m_bc = m_bc + 32'd1;
            if (mis) m_mc = m_mc + 32'd1;
            i = idx_of(ex_pc);
            if (m_valid[i] && (m_tag[i] == tag_of(ex_pc))) begin
                if (ex_is_jump)    m_ctr[i] = 3;
                else if (ex_bcond) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                else               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                if (taken) m_target[i] = ex_target;
            end else if (taken) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(ex_pc);
                m_target[i] = ex_target;
                m_ctr[i]    = ex_is_jump ? 3 : 2;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic        t;
        logic [31:0] npc;
        logic        taken;
        logic [31:0] apc;
        logic        mis;
        logic [31:0] cpc;
        m_predict(if_pc, t, npc);
        m_resolve(taken, apc, mis, cpc);
        check({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, ".pred_pc"}, pred_pc, npc);
        check({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, mis});
        check({tag, ".correct_pc"}, correct_pc, cpc);
        check({tag, ".branch_count"}, branch_count, m_bc);
        check({tag, ".mispredict_count"}, mispredict_count, m_mc);
    endtask

    // Inputs are already driven: settle, check, then take one clock edge.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic clock_only();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic probe(input logic [31:0] pc, input string tag);
        logic        t;
        logic [31:0] npc;
        if_pc = pc;
        #1;
        m_predict(pc, t, npc);
        check({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, ".pred_pc"}, pred_pc, npc);
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic jmp, input logic [31:0] pc,
                            input logic bc, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] ppc);
        ex_valid      = v;
        ex_is_branch  = br;
        ex_is_jump    = jmp;
        ex_pc         = pc;
        ex_bcond      = bc;
        ex_target     = tgt;
        ex_pred_taken = pt;
        ex_pred_pc    = ppc;
    endtask

    // Carry the model's fetch-time prediction with the EX instruction.
    task automatic drive_predicted(input logic v, input logic br, input logic jmp,
                                   input logic [31:0] pc, input logic bc, input logic [31:0] tgt);
        logic        t;
        logic [31:0] npc;
        m_predict(pc, t, npc);
        drive_ex(v, br, jmp, pc, bc, tgt, t, npc);
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) pc = pc | 32'h8000_0000;
        if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
        return pc;
    endfunction

    // ------------------------------------------------------------------
    // Directed sequence, then random traffic
    // ------------------------------------------------------------------
    initial begin
        m_reset();
        if_pc = 32'h100;
        // Reset held with a valid taken branch in EX: the update is discarded.
        reset = 1'b1;
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        clock_only();
        clock_only();
        reset = 1'b0;
        idle();

        // Cold predict.
        if_pc = 32'h100;
        #1;
        check("cold.pred_taken", {31'd0, pred_taken}, 32'd0);
        check("cold.pred_pc", pred_pc, 32'h104);
        tick("cold");
        probe(32'hFFFF_FFFC, "wrap");

        // Learn a taken branch; same-cycle lookup still sees the old entry.
        if_pc = 32'h100;
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        check("learn.mispredict", {31'd0, mispredict}, 32'd1);
        check("learn.correct_pc", correct_pc, 32'h80);
        check("hazard.pred_taken", {31'd0, pred_taken}, 32'd0);
        tick("learn");
        idle();
        #1;
        check("learned.pred_pc", pred_pc, 32'h80);
        check("learned.branch_count", branch_count, 32'd1);
        check("learned.mispredict_count", mispredict_count, 32'd1);
        tick("learned");

        // Hysteresis: one not-taken, four more (saturate low), one taken.
        if_pc = 32'h100;
        drive_predicted(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80);
        tick("nt1");
        for (int k = 0; k < 4; k++) begin
            drive_predicted(1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80);
            tick($sformatf("nt%0d", k + 2));
        end
        drive_predicted(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80);
        tick("t_after_snt");
        idle();
        #1;
        check("hyst.pred_taken", {31'd0, pred_taken}, 32'd0);
        tick("hyst");

        // Aliasing: a jump at 0x140 evicts 0x100 from the shared index.
        drive_predicted(1'b1, 1'b0, 1'b1, 32'h140, 1'b0, 32'h200);
        tick("alias_jump");
        idle();
        probe(32'h100, "alias_old");
        probe(32'h140, "alias_new");
        tick("alias");

        // Both flags set behaves as a jump.
        drive_predicted(1'b1, 1'b1, 1'b1, 32'h184, 1'b0, 32'h300);
        tick("both_flags");
        idle();
        probe(32'h184, "both_flags_pred");
        tick("both_flags_idle");

        // Invalid EX slot changes nothing; a not-taken miss allocates nothing.
        drive_predicted(1'b0, 1'b1, 1'b0, 32'h1C8, 1'b1, 32'h400);
        tick("bubble");
        drive_predicted(1'b1, 1'b1, 1'b0, 32'h3C4, 1'b0, 32'h500);
        tick("nt_miss");
        idle();
        probe(32'h1C8, "bubble_pred");
        probe(32'h3C4, "nt_miss_pred");
        tick("nt_miss_idle");

        // Reset mid-run with a taken branch in EX.
        reset = 1'b1;
        if_pc = 32'h140;
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick("reset_mid");
        reset = 1'b0;
        idle();
        probe(32'h140, "post_reset_140");
        check("post_reset.branch_count", branch_count, 32'd0);
        check("post_reset.mispredict_count", mispredict_count, 32'd0);
        probe(32'h184, "post_reset_184");
        tick("post_reset");

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] pc;
            logic        v;
            pc    = rand_pc();
            v     = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            if_pc = ($urandom_range(0, 1) == 0) ? pc : rand_pc();
            if ($urandom_range(0, 2) != 0) begin
                drive_predicted(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), pc,
                                1'($urandom_range(0, 1)), rand_pc());
            end else begin
                drive_ex(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0), pc,
                         1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 1) == 0) ? pc + 32'd4 : rand_pc());
            end
            tick($sformatf("rand%0d", n));
        end
        reset = 1'b0;
        idle();
        tick("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
